// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser: FSM states, SOF default, saturating increment.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } parser_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Increment that sticks at the all-ones value of a width-bit field (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'h1 << width) - 32'h1;
        return (val == max_val) ? val : val + 32'h1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count reflects an inc one cycle later; clr beats a same-cycle inc.
// Backpressure: none, one increment per cycle.
module sat_counter
    import uart_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from the rx FIFO, streams payload and flags frame status.
// Latency: popped byte on out_data next cycle; frame_ok/frame_err the cycle after CHK pop.
// Backpressure: stalls rx pops in PAYLOAD while the output register is full and not taken.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
    parameter int         MAX_LEN  = 16,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             rx_data_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] cksum_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    input  logic             err_cnt_clr
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    parser_state_t state_q;
    parser_state_t state_d;

    logic [7:0] sum_q;
    logic [7:0] remaining_q;
    logic [7:0] sum_next;
    logic       out_slot_free;
    logic       load_out;
    logic       ok_set;
    logic       cksum_err_inc;
    logic       len_err_inc;

    assign sum_next      = sum_q + rx_data;
    assign out_slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_data_ready) begin
            unique case (state_q)
                HUNT: begin
                    if (rx_data == SOF_BYTE) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (rx_data == 8'd0) begin
                        state_d = CHECK;
                    end else if (rx_data > MAX_LEN_B) begin
                        state_d = HUNT;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (remaining_q == 8'd1) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Pops are gated only in PAYLOAD, where each byte needs a free output slot.
    always_comb begin
        rx_data_ready = rx_data_valid && ((state_q != PAYLOAD) || out_slot_free);
        load_out      = rx_data_ready && (state_q == PAYLOAD);
        ok_set        = rx_data_ready && (state_q == CHECK) && (sum_next == 8'd0);
        cksum_err_inc = rx_data_ready && (state_q == CHECK) && (sum_next != 8'd0);
        len_err_inc   = rx_data_ready && (state_q == LEN) && (rx_data > MAX_LEN_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            remaining_q <= '0;
        end else if (rx_data_ready) begin
            if (state_q == LEN) begin
                sum_q       <= rx_data;
                remaining_q <= rx_data;
            end else if (state_q == PAYLOAD) begin
                sum_q       <= sum_next;
                remaining_q <= remaining_q - 8'd1;
            end
        end
    end

    // Single output stage: a load and a downstream take may coincide for full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_data  <= rx_data;
            out_valid <= 1'b1;
            out_last  <= (remaining_q == 8'd1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= ok_set;
            frame_err <= cksum_err_inc || len_err_inc;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cksum_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cksum_err_inc),
        .clr   (err_cnt_clr),
        .cnt   (cksum_err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_len_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (len_err_inc),
        .clr   (err_cnt_clr),
        .cnt   (len_err_cnt)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Table-driven frame vectors plus hand sequences for stall, reset and counter saturation.
module tb_uart_frame_parser;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SOF     = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] cksum_err_cnt;
    logic [7:0] len_err_cnt;
    logic       err_cnt_clr;

    uart_frame_parser #(.SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .cksum_err_cnt (cksum_err_cnt),
        .len_err_cnt   (len_err_cnt),
        .err_cnt_clr   (err_cnt_clr)
    );

    typedef struct {
        int         ngarb;
        logic [7:0] garb [2];
        logic [7:0] len;
        logic [7:0] pay [4];
        logic [7:0] ck_b;
        bit         exp_ok;
        int         exp_ck;
        int         exp_len;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    bit         sb_en  = 1'b1;
    logic [7:0] rxq [$];
    logic [8:0] dq  [$];
    bit         stq [$];
    vec_t       vecs [7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic vec_t mk(int ng, logic [7:0] g0, logic [7:0] g1, logic [7:0] len,
                                logic [7:0] p0, logic [7:0] p1, logic [7:0] p2, logic [7:0] p3,
                                logic [7:0] ck_b, bit ok, int eck, int eln);
        vec_t v;
        v.ngarb   = ng;
        v.garb[0] = g0;
        v.garb[1] = g1;
        v.len     = len;
        v.pay[0]  = p0;
        v.pay[1]  = p1;
        v.pay[2]  = p2;
        v.pay[3]  = p3;
        v.ck_b    = ck_b;
        v.exp_ok  = ok;
        v.exp_ck  = eck;
        v.exp_len = eln;
        return v;
    endfunction

    // rx FIFO model: head is presented 1 ns after each edge, popped when the DUT strobes ready.
    initial begin
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        forever begin
            @(posedge clk);
            if (rx_data_valid && rx_data_ready && rxq.size() > 0) begin
                void'(rxq.pop_front());
            end
            #1;
            rx_data_valid = (rxq.size() > 0);
            rx_data       = (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    // Scoreboard: compare every output handshake and status pulse against the queues.
    initial begin
        logic [8:0] e;
        bit         s;
        forever begin
            @(negedge clk);
            if (sb_en && out_valid && out_ready) begin
                if (dq.size() == 0) begin
                    fail($sformatf("unexpected_out data %0h", out_data));
                end else begin
                    e = dq.pop_front();
                    chk("out_last_data", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end
            if (sb_en && (frame_ok || frame_err)) begin
                if (stq.size() == 0) begin
                    fail($sformatf("unexpected_status ok %0b err %0b", frame_ok, frame_err));
                end else begin
                    s = stq.pop_front();
                    chk("frame_status", {30'd0, frame_ok, frame_err}, {30'd0, s, !s});
                end
            end
        end
    end

    task automatic queue_vec(input vec_t v);
        for (int i = 0; i < v.ngarb; i++) rxq.push_back(v.garb[i]);
        rxq.push_back(SOF);
        rxq.push_back(v.len);
        stq.push_back(v.exp_ok);
        if (int'(v.len) > MAX_LEN) return;
        for (int i = 0; i < int'(v.len); i++) begin
            rxq.push_back(v.pay[i]);
            dq.push_back({(i == int'(v.len) - 1), v.pay[i]});
        end
        rxq.push_back(v.ck_b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((rxq.size() != 0 || dq.size() != 0 || stq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail({name, "_timeout"});
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        err_cnt_clr = 1'b0;

        vecs[0] = mk(0, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h97, 1'b1, 0, 0);
        vecs[1] = mk(0, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h98, 1'b0, 1, 0);
        vecs[2] = mk(2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1, 0);
        vecs[3] = mk(0, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 1);
        vecs[4] = mk(0, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 8'hFB, 1'b1, 1, 1);
        vecs[5] = mk(0, 8'h00, 8'h00, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b1, 1, 1);
        vecs[6] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 2, 1);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {21'd0, rx_data_ready, out_valid, out_last, frame_ok, frame_err, out_data},
            32'd0);
        chk("reset_counters", {16'd0, cksum_err_cnt, len_err_cnt}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            queue_vec(vecs[i]);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_cksum_cnt", i), {24'd0, cksum_err_cnt}, vecs[i].exp_ck);
            chk($sformatf("vec%0d_len_cnt", i), {24'd0, len_err_cnt}, vecs[i].exp_len);
        end

        // Stall the output register while it holds the second payload byte.
        queue_vec(vecs[0]);
        n = 0;
        while (!(out_valid && out_data == 8'h11) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("bp_wait_first_byte");
        @(posedge clk);
        #2 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rx_ready_low", {31'd0, rx_data_ready}, 32'd0);
            chk("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_idle("bp");
        chk("bp_cksum_cnt", {24'd0, cksum_err_cnt}, 32'd2);

        // Reset in the middle of a payload drops the frame silently.
        sb_en = 1'b0;
        rxq.push_back(SOF);
        rxq.push_back(8'h05);
        rxq.push_back(8'h01);
        rxq.push_back(8'h02);
        rxq.push_back(8'h03);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("rst_wait_payload");
        rxq.delete();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            {21'd0, rx_data_ready, out_valid, out_last, frame_ok, frame_err, out_data},
            32'd0);
        chk("midrst_counters", {16'd0, cksum_err_cnt, len_err_cnt}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        dq.delete();
        stq.delete();
        sb_en = 1'b1;
        queue_vec(vecs[2]);
        wait_idle("post_reset");
        chk("post_reset_counters", {16'd0, cksum_err_cnt, len_err_cnt}, 32'd0);

        // 260 bad frames saturate the checksum counter.
        for (int i = 0; i < 260; i++) queue_vec(vecs[6]);
        wait_idle("saturate");
        chk("sat_cksum_cnt", {24'd0, cksum_err_cnt}, 32'hFF);
        chk("sat_len_cnt", {24'd0, len_err_cnt}, 32'd0);

        // Clear asserted in the same cycle the bad checksum is popped.
        rxq.push_back(SOF);
        rxq.push_back(8'h00);
        rxq.push_back(8'h07);
        stq.push_back(1'b0);
        n = 0;
        while (!(rxq.size() == 1 && rx_data_valid && rx_data_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("clr_wait_chk");
        err_cnt_clr = 1'b1;
        @(posedge clk);
        #2 err_cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_beats_inc", {24'd0, cksum_err_cnt}, 32'd0);
        wait_idle("clr_race");

        queue_vec(vecs[6]);
        wait_idle("after_clr");
        chk("inc_after_clr", {24'd0, cksum_err_cnt}, 32'd1);

        @(posedge clk);
        #2 err_cnt_clr = 1'b1;
        @(posedge clk);
        #2 err_cnt_clr = 1'b0;
        @(negedge clk);
        chk("plain_clr", {16'd0, cksum_err_cnt, len_err_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Consumer of the host receive interface of the UART top. Runs in the core clock domain on the rx FIFO read side.
- Hunts for a start-of-frame byte, reads a length byte, forwards payload bytes on a valid/ready stream, and validates a trailing checksum.
- Reports per-frame good/bad status pulses and keeps saturating error counters for the core.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, largest legal payload length in bytes (1..255).
- CNT_W, 8, width of saturating error counters.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  head byte of rx FIFO (valid when rx_data_valid)
- rx_data_valid  input  1  rx FIFO non-empty
- rx_data_ready  output  1  pop strobe to rx FIFO; one byte consumed per cycle asserted
- out_data  output  8  payload byte
- out_valid  output  1  out_data valid
- out_last  output  1  qualifies final payload byte of frame
- out_ready  input  1  downstream accepts byte when out_valid&&out_ready
- frame_ok  output  1  one-cycle pulse, checksum matched
- frame_err  output  1  one-cycle pulse, checksum mismatch or illegal length
- cksum_err_cnt  output  CNT_W  saturating count of checksum failures
- len_err_cnt  output  CNT_W  saturating count of length violations
- err_cnt_clr  input  1  synchronous clear of both counters (has priority over increment)

Behaviour:
- Reset: state=HUNT; rx_data_ready, out_valid, out_last, frame_ok, frame_err=0; out_data=0; counters=0; running sum=0.
- Frame format: SOF, LEN, LEN payload bytes, CHK. Legal when (LEN + sum(payload) + CHK) mod 256 == 0.
- Consume rule: rx_data_ready = rx_data_valid && (state!=PAYLOAD || out_slot_free). out_slot_free = !out_valid || out_ready. rx_data_ready is combinational and never asserted when rx_data_valid=0.
- States:
  - HUNT: on a popped byte == SOF_BYTE go to LEN. Other bytes are popped and discarded.
  - LEN: pop byte; sum<=byte; remaining<=byte.
    - byte==0 -> CHECK.
    - byte>MAX_LEN -> frame_err pulse, len_err_cnt++, HUNT.
    - otherwise -> PAYLOAD.
  - PAYLOAD: each pop loads out_data<=byte and out_valid<=1; sum+=byte (8-bit wrap); remaining--. out_last<=1 when remaining==1, and go to CHECK after that byte.
  - CHECK: pop byte. (sum+byte)[7:0]==0 -> frame_ok pulse; else frame_err pulse and cksum_err_cnt++. Go to HUNT.
- Output register: a single stage. out_valid clears on out_ready when no new byte is loaded that cycle. Simultaneous handshake-out and load-in is allowed, giving full throughput of 1 byte/cycle.
- Latency: rx byte popped in cycle N appears on out_data in cycle N+1. frame_ok/err is asserted the cycle after CHK is popped.
- Payload is forwarded before validation. Downstream must use frame_ok/frame_err, which always follow the out_last byte's load.
- SOF inside a payload is treated as data; there is no resync mid-frame.
- Backpressure: while out_ready=0 and out_valid=1 in PAYLOAD, no pop occurs and state/sum hold. The rx FIFO absorbs the stall.
- LEN==0: no out_valid, no out_last; CHK must equal 8'h00 for frame_ok.
- Counters saturate at all-ones. err_cnt_clr wins over a same-cycle increment.
- Asynchronous reset mid-frame drops the partial frame with no status pulse. out_valid clears immediately.

Decomposition:
- Package uart_pkg:
  - state enum parser_state_t {HUNT, LEN, PAYLOAD, CHECK}
  - localparam SOF default
  - function for saturating increment
- One natural sub-module: sat_counter (CNT_W width, inc, clr, async reset), instantiated twice.
- The FSM, sum and output register stay in uart_frame_parser.

Test Plan:
- Good frame: feed A5 03 11 22 33 97 -> out 11,22,33 with out_last on 33; frame_ok=1 one cycle; counters 0.
- Bad checksum: A5 03 11 22 33 98 -> payload forwarded; frame_err pulse; cksum_err_cnt=1.
- Garbage then zero-length: 00 FF A5 00 00 -> first two bytes discarded with no output; frame_ok pulse; out_valid never asserted.
- Length violation with MAX_LEN=16: A5 11 ... -> frame_err, len_err_cnt=1, parser back in HUNT. Next A5 02 01 02 FB -> frame_ok.
- Backpressure: good frame with out_ready low for 5 cycles on the 2nd byte -> rx_data_ready=0 during the stall; no byte loss or duplication; frame_ok still pulses.
- Reset and saturation: rst_n low mid-PAYLOAD -> all outputs 0, state HUNT. Then 260 bad-checksum frames -> cksum_err_cnt=8'hFF. err_cnt_clr -> 0.
